// File: rtl/axi_lite_dma_ctrl_if.sv
// AXI4-Lite master/slave bundle used by the single-word-in-flight copy engine.
interface axi_lite_dma_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10
) ();
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );

   modport slave (
      input  awaddr, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axi_lite_dma_ctrl.sv
// Word-by-word memory copy engine over AXI4-Lite: read one word, write it back,
// repeat; stops on the first error response.
module axi_lite_dma_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LEN_WIDTH  = 8
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   axi_lite_dma_ctrl_if.master   m
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(STRB_WIDTH);

   typedef enum logic [2:0] {
      IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, FINISH
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] src_q, dst_q;
   logic [LEN_WIDTH-1:0]  remaining;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  aw_done, w_done, aw_done_nxt, w_done_nxt;
   logic                  arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
   logic                  arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
   logic                  busy_d, done_d;
   logic                  start_ok_c, last_word_c;

   assign start_ok_c  = (state == IDLE) && start;
   assign last_word_c = (remaining == LEN_WIDTH'(1));

   // State register plus registered handshake/status outputs
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state     <= IDLE;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         aw_done   <= aw_done_nxt;
         w_done    <= w_done_nxt;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

   // Next-state logic; AW and W handshakes are tracked separately in WR_REQ
   always_comb begin
      state_nxt   = state;
      aw_done_nxt = 1'b0;
      w_done_nxt  = 1'b0;
      case (state)
         IDLE:    if (start) state_nxt = (len != '0) ? RD_ADDR : FINISH;
         RD_ADDR: if (arvalid_q && m.arready) state_nxt = RD_DATA;
         RD_DATA: if (m.rvalid) state_nxt = (m.rresp != 2'b00) ? FINISH : WR_REQ;
         WR_REQ: begin
            aw_done_nxt = aw_done || (awvalid_q && m.awready);
            w_done_nxt  = w_done  || (wvalid_q && m.wready);
            if (aw_done_nxt && w_done_nxt) state_nxt = WR_RESP;
         end
         WR_RESP: begin
            if (m.bvalid) begin
               if (m.bresp != 2'b00 || last_word_c) state_nxt = FINISH;
               else                                 state_nxt = RD_ADDR;
            end
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode from the next state so every output leaves a flop
   always_comb begin
      arvalid_d = (state_nxt == RD_ADDR);
      rready_d  = (state_nxt == RD_DATA);
      awvalid_d = (state_nxt == WR_REQ) && !aw_done_nxt;
      wvalid_d  = (state_nxt == WR_REQ) && !w_done_nxt;
      bready_d  = (state_nxt == WR_RESP);
      busy_d    = (state_nxt != IDLE);
      done_d    = (state_nxt == FINISH);
   end

   // Addresses, word count, captured data and sticky error
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         src_q     <= '0;
         dst_q     <= '0;
         remaining <= '0;
         rdata_q   <= '0;
         error     <= 1'b0;
      end else begin
         if (start_ok_c) begin
            src_q     <= src_addr;
            dst_q     <= dst_addr;
            remaining <= len;
            error     <= 1'b0;
         end
         if (state == RD_DATA && m.rvalid) begin
            rdata_q <= m.rdata;
            if (m.rresp != 2'b00) error <= 1'b1;
         end
         if (state == WR_RESP && m.bvalid) begin
            if (m.bresp != 2'b00) begin
               error <= 1'b1;
            end else begin
               remaining <= remaining - LEN_WIDTH'(1);
               src_q     <= src_q + STEP;
               dst_q     <= dst_q + STEP;
            end
         end
      end
   end

   assign m.araddr  = src_q;
   assign m.arvalid = arvalid_q;
   assign m.rready  = rready_q;
   assign m.awaddr  = dst_q;
   assign m.awvalid = awvalid_q;
   assign m.wdata   = rdata_q;
   assign m.wstrb   = {STRB_WIDTH{1'b1}};
   assign m.wvalid  = wvalid_q;
   assign m.bready  = bready_q;
endmodule

// File: tb/tb_axi_lite_dma_ctrl.sv
// Directed bench for axi_lite_dma_ctrl with a behavioural AXI4-Lite memory slave.
module tb_axi_lite_dma_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [9:0] src_addr = '0;
   logic [9:0] dst_addr = '0;
   logic [7:0] len = '0;
   logic       busy, done, error;

   int vectors = 0;
   int miscompares = 0;

   axi_lite_dma_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) m ();

   axi_lite_dma_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LEN_WIDTH(8)) dut (
      .ACLK(clk), .ARESETN(rst_n), .start(start), .src_addr(src_addr),
      .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .error(error), .m(m)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Slave model state and controls
   logic [31:0] mem [0:255];
   int          wr_log [$];
   int          rd_total = 0, wr_total = 0, err_word = -1, r_fix = 0;
   bit          rand_en = 1'b0;
   int          done_cnt = 0, valid_cycles = 0;

   function automatic int pick();
      return rand_en ? int'($urandom_range(0, 3)) : 0;
   endfunction

   always @(posedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (m.arvalid || m.awvalid || m.wvalid) valid_cycles <= valid_cycles + 1;
   end

   // Memory slave: decisions at negedge, handshakes complete on the next posedge
   initial begin
      bit          r_pend, b_pend, aw_got, w_got, ar_seen, aw_seen, w_seen;
      int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
      logic [9:0]  r_addr, aw_addr, ar_first, aw_first;
      logic [31:0] w_data, w_first;
      for (int i = 0; i < 256; i++) mem[i] = 32'h5000_0000 + 32'(i);
      mem[0] = 32'h1122_3344; mem[1] = 32'hDEAD_BEEF;
      mem[2] = 32'hCAFE_BABE; mem[3] = 32'h0F0F_0F0F;
      mem[4] = 32'hA5A5_0001; mem[5] = 32'hA5A5_0002;
      mem[8'h42] = 32'h6666_6666;
      {r_pend, b_pend, aw_got, w_got, ar_seen, aw_seen, w_seen} = '0;
      {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt} = '0;
      {r_addr, aw_addr, ar_first, aw_first, w_data, w_first} = '0;
      m.arready = 0; m.rvalid = 0; m.rdata = '0; m.rresp = '0;
      m.awready = 0; m.wready = 0; m.bvalid = 0; m.bresp = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            {r_pend, b_pend, aw_got, w_got, ar_seen, aw_seen, w_seen} = '0;
            {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt} = '0;
            m.arready = 0; m.rvalid = 0; m.awready = 0; m.wready = 0; m.bvalid = 0;
         end else begin
            m.bvalid = 0; m.bresp = '0;
            if (b_pend && m.bready) begin
               if (b_cnt == 0) begin
                  m.bvalid = 1;
                  m.bresp  = (wr_total == err_word) ? 2'b10 : 2'b00;
                  b_pend = 0; aw_got = 0; w_got = 0;
               end else b_cnt--;
            end
            m.rvalid = 0;
            if (r_pend && m.rready) begin
               if (r_cnt == 0) begin
                  m.rvalid = 1; m.rdata = mem[r_addr[9:2]]; m.rresp = 2'b00; r_pend = 0;
               end else r_cnt--;
            end
            m.arready = 0;
            if (m.arvalid && !r_pend) begin
               check("ar_while_write", 32'({m.awvalid, m.wvalid, m.bready}), 32'd0);
               if (ar_seen) check("araddr_stable", 32'(m.araddr), 32'(ar_first));
               else begin ar_first = m.araddr; ar_seen = 1; end
               if (ar_cnt == 0) begin
                  m.arready = 1; r_pend = 1; r_addr = m.araddr; ar_seen = 0;
                  r_cnt = rand_en ? pick() : r_fix; ar_cnt = pick(); rd_total++;
               end else ar_cnt--;
            end
            m.awready = 0;
            if (m.awvalid && !aw_got) begin
               if (aw_seen) check("awaddr_stable", 32'(m.awaddr), 32'(aw_first));
               else begin aw_first = m.awaddr; aw_seen = 1; end
               if (aw_cnt == 0) begin
                  m.awready = 1; aw_got = 1; aw_addr = m.awaddr; aw_seen = 0; aw_cnt = pick();
               end else aw_cnt--;
            end
            m.wready = 0;
            if (m.wvalid && !w_got) begin
               if (w_seen) check("wdata_stable", m.wdata, w_first);
               else begin w_first = m.wdata; w_seen = 1; end
               if (w_cnt == 0) begin
                  check("wstrb", 32'(m.wstrb), 32'hF);
                  m.wready = 1; w_got = 1; w_data = m.wdata; w_seen = 0; w_cnt = pick();
               end else w_cnt--;
            end
            if (aw_got && w_got && !b_pend) begin
               mem[aw_addr[9:2]] = w_data;
               wr_log.push_back(int'(aw_addr));
               wr_total++; b_pend = 1; b_cnt = pick();
            end
         end
      end
   end

   task automatic run_start(input logic [9:0] s, input logic [9:0] d, input logic [7:0] n);
      @(posedge clk); #1;
      src_addr = s; dst_addr = d; len = n; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 500) begin @(posedge clk); #1; n++; end
      check(tag, 32'(busy), 32'd0);
   endtask

   task automatic check_quiet(input string tag);
      check(tag, 32'({busy, done, error, m.arvalid, m.rready, m.awvalid, m.wvalid, m.bready}), 32'd0);
   endtask

   initial begin
      int d0, r0, w0, v0, n;
      repeat (2) @(posedge clk);
      #1;
      check_quiet("reset_outputs");
      rst_n = 1'b1;

      // Single-word copy
      d0 = done_cnt;
      run_start(10'h004, 10'h040, 8'd1);
      check("t30_busy", 32'(busy), 32'd1);
      wait_idle("t30_timeout");
      check("t30_data", mem[8'h10], 32'hDEAD_BEEF);
      check("t30_done", 32'(done_cnt - d0), 32'd1);
      check("t30_error", 32'(error), 32'd0);

      // Four words under random slave backpressure
      rand_en = 1'b1;
      d0 = done_cnt;
      run_start(10'h000, 10'h080, 8'd4);
      wait_idle("t31_timeout");
      rand_en = 1'b0;
      check("t31_w0", mem[8'h20], 32'h1122_3344);
      check("t31_w1", mem[8'h21], 32'hDEAD_BEEF);
      check("t31_w2", mem[8'h22], 32'hCAFE_BABE);
      check("t31_w3", mem[8'h23], 32'h0F0F_0F0F);
      check("t31_done", 32'(done_cnt - d0), 32'd1);
      check("t31_error", 32'(error), 32'd0);

      // Zero-length request: straight to FINISH, no bus traffic
      v0 = valid_cycles;
      run_start(10'h008, 10'h008, 8'd0);
      check("t32_finish", 32'({busy, done}), 32'h3);
      @(posedge clk); #1;
      check("t32_idle", 32'({busy, done}), 32'h0);
      check("t32_no_valid", 32'(valid_cycles - v0), 32'd0);
      check("t32_error", 32'(error), 32'd0);

      // Write error on the second word aborts the copy
      d0 = done_cnt; r0 = rd_total; w0 = wr_total;
      err_word = wr_total + 2;
      run_start(10'h000, 10'h100, 8'd4);
      wait_idle("t33_timeout");
      err_word = -1;
      check("t33_error", 32'(error), 32'd1);
      check("t33_done", 32'(done_cnt - d0), 32'd1);
      check("t33_reads", 32'(rd_total - r0), 32'd2);
      check("t33_writes", 32'(wr_total - w0), 32'd2);
      check("t33_untouched", mem[8'h42], 32'h6666_6666);

      // Destination wraps past the top; a start while busy is ignored
      d0 = done_cnt; r0 = rd_total; w0 = wr_total;
      run_start(10'h010, 10'h3FC, 8'd2);
      check("t34_error_cleared", 32'(error), 32'd0);
      check("t34_busy", 32'(busy), 32'd1);
      run_start(10'h020, 10'h300, 8'd3);
      wait_idle("t34_timeout");
      check("t34_writes", 32'(wr_total - w0), 32'd2);
      check("t34_addr0", 32'(wr_log[wr_log.size()-2]), 32'h3FC);
      check("t34_addr1", 32'(wr_log[wr_log.size()-1]), 32'h000);
      check("t34_data0", mem[8'hFF], 32'hA5A5_0001);
      check("t34_data1", mem[8'h00], 32'hA5A5_0002);
      check("t34_reads", 32'(rd_total - r0), 32'd2);
      check("t34_done", 32'(done_cnt - d0), 32'd1);

      // Asynchronous reset while waiting for read data
      r_fix = 5;
      run_start(10'h000, 10'h200, 8'd2);
      n = 0;
      while (!m.rready && n < 50) begin @(posedge clk); #1; n++; end
      check("t35_in_rd_data", 32'(m.rready), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_quiet("t35_reset_async");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1; r_fix = 0;
      repeat (3) begin @(posedge clk); #1; end
      check_quiet("t35_not_resumed");
      d0 = done_cnt;
      run_start(10'h004, 10'h044, 8'd1);
      wait_idle("t35_timeout");
      check("t35_data", mem[8'h11], 32'hDEAD_BEEF);
      check("t35_done", 32'(done_cnt - d0), 32'd1);
      check("t35_error", 32'(error), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
